// File: rtl/fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Purpose:
//   Generates the fetch PC stream for the front end. Each accepted fetch is
//   recorded in a small prediction queue together with its predicted next PC,
//   taken flag and BTB hit flag. Decode later drains the queue. A commit-stage
//   redirect flushes the queue and restarts fetch at the corrected address.
//
// Optional feature:
//   FETCH_PC_STALL_COUNTER_EN - when defined, adds a 32-bit saturating
//   stall_count output. It counts cycles spent in RUN without an accepted
//   fetch.
//
// Ports:
//   clock            - sole clock, rising edge
//   reset            - asynchronous, active-low reset
//   fetch_PC         - address presented to the predictor and I-cache
//   fetch_valid      - fetch_PC is valid this cycle
//   icache_ready     - I-cache accepts fetch_PC this cycle
//   target_PC        - predictor target for the current fetch_PC
//   target_take      - predictor taken decision
//   BTB_hit          - predictor jump-hit flag
//   redirect_valid   - mispredict/exception redirect (highest priority)
//   redirect_PC      - corrected fetch address
//   deq_valid        - queue head is valid
//   deq_ready        - decode consumes the head
//   deq_PC           - PC of the head fetch
//   deq_pred_target  - predicted next PC of the head fetch
//   deq_pred_take    - taken prediction of the head fetch
//   deq_BTB_hit      - BTB hit flag captured with the head fetch
//   queue_full       - queue holds QUEUE_DEPTH entries
//   stall_count      - (optional) saturating RUN-without-accept cycle counter
// ----------------------------------------------------------------------------
module fetch_pc_sequencer #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] fetch_PC,
    output logic            fetch_valid,
    input  logic            icache_ready,
    input  logic [XLEN-1:0] target_PC,
    input  logic            target_take,
    input  logic            BTB_hit,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_PC,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [XLEN-1:0] deq_PC,
    output logic [XLEN-1:0] deq_pred_target,
    output logic            deq_pred_take,
    output logic            deq_BTB_hit,
    output logic            queue_full
`ifdef FETCH_PC_STALL_COUNTER_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_reg;
    logic [XLEN-1:0]   fetch_pc_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;

    // Queue storage; no reset so it can map onto RAM. Emptiness is tracked
    // by count_reg alone, which the asynchronous reset clears instantly.
    logic [XLEN-1:0]   pc_mem     [QUEUE_DEPTH];
    logic [XLEN-1:0]   target_mem [QUEUE_DEPTH];
    logic              take_mem   [QUEUE_DEPTH];
    logic              btb_mem    [QUEUE_DEPTH];

    logic              accept;
    logic              pop;
    logic [XLEN-1:0]   next_pc;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    assign queue_full  = (count_reg == CNT_W'(QUEUE_DEPTH));
    assign deq_valid   = (count_reg != '0);
    assign fetch_valid = (state_reg == RUN) && !queue_full && !redirect_valid;
    assign fetch_PC    = fetch_pc_reg;

    // fetch_valid already excludes redirect; pop must be masked explicitly.
    assign accept  = fetch_valid && icache_ready;
    assign pop     = deq_valid && deq_ready && !redirect_valid;
    assign next_pc = align_pc(target_take ? target_PC : fetch_pc_reg + XLEN'(4));

    // Head data is forced to zero whenever the queue is empty.
    assign deq_PC          = deq_valid ? pc_mem[rd_ptr_reg]     : '0;
    assign deq_pred_target = deq_valid ? target_mem[rd_ptr_reg] : '0;
    assign deq_pred_take   = deq_valid ? take_mem[rd_ptr_reg]   : 1'b0;
    assign deq_BTB_hit     = deq_valid ? btb_mem[rd_ptr_reg]    : 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= align_pc(RESET_PC);
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else if (redirect_valid) begin
            // Redirect overrides everything, in every state.
            state_reg    <= FLUSH;
            fetch_pc_reg <= align_pc(redirect_PC);
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE:    state_reg <= RUN;
                FLUSH:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
            if (accept) begin
                fetch_pc_reg <= next_pc;
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (accept && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!accept && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            pc_mem[wr_ptr_reg]     <= fetch_pc_reg;
            target_mem[wr_ptr_reg] <= next_pc;
            take_mem[wr_ptr_reg]   <= target_take;
            btb_mem[wr_ptr_reg]    <= BTB_hit;
        end
    end

`ifdef FETCH_PC_STALL_COUNTER_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if ((state_reg == RUN) && !accept && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_sequencer
//
// Directed testbench for fetch_pc_sequencer (XLEN=64, QUEUE_DEPTH=4,
// RESET_PC=0). Inputs change 1ns after a rising edge; outputs are sampled in
// that same window, away from the edge.
// ----------------------------------------------------------------------------
module tb_fetch_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] fetch_PC;
    logic        fetch_valid;
    logic        icache_ready = 1'b0;
    logic [63:0] target_PC = '0;
    logic        target_take = 1'b0;
    logic        BTB_hit = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_PC = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [63:0] deq_PC;
    logic [63:0] deq_pred_target;
    logic        deq_pred_take;
    logic        deq_BTB_hit;
    logic        queue_full;
`ifdef FETCH_PC_STALL_COUNTER_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_pc_sequencer #(
        .XLEN        (64),
        .RESET_PC    (64'h0),
        .QUEUE_DEPTH (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_PC        (fetch_PC),
        .fetch_valid     (fetch_valid),
        .icache_ready    (icache_ready),
        .target_PC       (target_PC),
        .target_take     (target_take),
        .BTB_hit         (BTB_hit),
        .redirect_valid  (redirect_valid),
        .redirect_PC     (redirect_PC),
        .deq_valid       (deq_valid),
        .deq_ready       (deq_ready),
        .deq_PC          (deq_PC),
        .deq_pred_target (deq_pred_target),
        .deq_pred_take   (deq_pred_take),
        .deq_BTB_hit     (deq_BTB_hit),
        .queue_full      (queue_full)
`ifdef FETCH_PC_STALL_COUNTER_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_fetch_pc", fetch_PC, 64'h0);
        check("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
        check("rst_queue_full", {63'd0, queue_full}, 64'd0);
        check("rst_deq_pc", deq_PC, 64'h0);
        check("rst_deq_target", deq_pred_target, 64'h0);

        // Fill the queue with sequential fetches
        icache_ready = 1'b1;
        #20 reset = 1'b1;
        tick();                                   // IDLE -> RUN
        check("run_fetch_valid", {63'd0, fetch_valid}, 64'd1);
        check("run_fetch_pc0", fetch_PC, 64'h0);
        tick();
        check("seq_fetch_pc4", fetch_PC, 64'h4);
        check("seq_deq_valid", {63'd0, deq_valid}, 64'd1);
        check("seq_deq_pc", deq_PC, 64'h0);
        check("seq_deq_target", deq_pred_target, 64'h4);
        tick();
        check("seq_fetch_pc8", fetch_PC, 64'h8);
        tick();
        check("seq_fetch_pcC", fetch_PC, 64'hC);
        tick();
        check("full_flag", {63'd0, queue_full}, 64'd1);
        check("full_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("full_fetch_pc", fetch_PC, 64'h10);

        // Pop while full: no push that cycle, push resumes afterwards
        deq_ready = 1'b1;
        tick();
        check("pop_full_flag", {63'd0, queue_full}, 64'd0);
        check("pop_deq_pc", deq_PC, 64'h4);
        check("pop_no_push_pc", fetch_PC, 64'h10);
        deq_ready = 1'b0;
        tick();
        check("refill_full", {63'd0, queue_full}, 64'd1);
        check("refill_fetch_pc", fetch_PC, 64'h14);

        // Redirect with simultaneous accept and pop
        redirect_valid = 1'b1;
        redirect_PC    = 64'h8000;
        deq_ready      = 1'b1;
        check("redir_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        tick();
        redirect_valid = 1'b0;
        deq_ready      = 1'b0;
        check("flush_deq_valid", {63'd0, deq_valid}, 64'd0);
        check("flush_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("flush_queue_full", {63'd0, queue_full}, 64'd0);
        tick();
        check("after_flush_pc", fetch_PC, 64'h8000);
        check("after_flush_valid", {63'd0, fetch_valid}, 64'd1);

        // Taken branch with unaligned target
        redirect_valid = 1'b1;
        redirect_PC    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("br_start_pc", fetch_PC, 64'h100);
        target_take = 1'b1;
        target_PC   = 64'h203;
        BTB_hit     = 1'b1;
        tick();
        check("br_fetch_pc", fetch_PC, 64'h200);
        check("br_deq_pc", deq_PC, 64'h100);
        check("br_deq_target", deq_pred_target, 64'h200);
        check("br_deq_take", {63'd0, deq_pred_take}, 64'd1);
        check("br_deq_btb", {63'd0, deq_BTB_hit}, 64'd1);

        // Simultaneous push and pop keeps the count at one
        target_take = 1'b0;
        BTB_hit     = 1'b0;
        deq_ready   = 1'b1;
        tick();
        check("pp_fetch_pc", fetch_PC, 64'h204);
        check("pp_deq_valid", {63'd0, deq_valid}, 64'd1);
        check("pp_deq_pc", deq_PC, 64'h200);
        check("pp_deq_target", deq_pred_target, 64'h204);
        check("pp_deq_take", {63'd0, deq_pred_take}, 64'd0);
        deq_ready = 1'b0;

        // Back-to-back redirects: the last one wins
        redirect_valid = 1'b1;
        redirect_PC    = 64'h1000;
        tick();
        redirect_PC    = 64'h2007;
        tick();
        redirect_valid = 1'b0;
        check("last_redir_flush", {63'd0, fetch_valid}, 64'd0);
        tick();
        check("last_redir_pc", fetch_PC, 64'h2004);
        check("last_redir_valid", {63'd0, fetch_valid}, 64'd1);

        // +4 wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_PC    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_start_pc", fetch_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_fetch_pc", fetch_PC, 64'h0);
        check("wrap_deq_pc", deq_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_deq_target", deq_pred_target, 64'h0);
        tick();
        check("wrap_next_pc", fetch_PC, 64'h4);

        // Asynchronous reset between clock edges
        #2 reset = 1'b0;
        #1;
        check("arst_fetch_pc", fetch_PC, 64'h0);
        check("arst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("arst_deq_valid", {63'd0, deq_valid}, 64'd0);
        check("arst_queue_full", {63'd0, queue_full}, 64'd0);
        check("arst_deq_pc", deq_PC, 64'h0);
`ifdef FETCH_PC_STALL_COUNTER_EN
        check("arst_stall_count", {32'd0, stall_count}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, prediction-queue entries; power of 2, minimum 2.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port fetch_PC, output, XLEN, address presented to the predictor and I-cache.
REQ-007 SHALL have port fetch_valid, output, 1, fetch_PC is valid this cycle.
REQ-008 SHALL have port icache_ready, input, 1, I-cache accepts fetch_PC this cycle.
REQ-009 SHALL have port target_PC, input, XLEN, predictor target for the current fetch_PC.
REQ-010 SHALL have port target_take, input, 1, predictor taken decision.
REQ-011 SHALL have port BTB_hit, input, 1, predictor jump-hit flag.
REQ-012 SHALL have port redirect_valid, input, 1, commit-stage mispredict or exception redirect.
REQ-013 SHALL have port redirect_PC, input, XLEN, corrected fetch address.
REQ-014 SHALL have port deq_valid, output, 1, queue head is valid.
REQ-015 SHALL have port deq_ready, input, 1, decode consumes the head.
REQ-016 SHALL have port deq_PC, output, XLEN, PC of the head fetch.
REQ-017 SHALL have port deq_pred_target, output, XLEN, predicted next PC of the head fetch.
REQ-018 SHALL have port deq_pred_take, output, 1, taken prediction of the head fetch.
REQ-019 SHALL have port deq_BTB_hit, output, 1, BTB_hit captured for the head fetch; later returned as update_BTB_hit.
REQ-020 SHALL have port queue_full, output, 1, count equals QUEUE_DEPTH.

Function
REQ-021 FSM states SHALL be IDLE, RUN and FLUSH; IDLE moves to RUN one cycle after reset release; FLUSH moves to RUN after one cycle.
REQ-022 fetch_valid SHALL equal (state==RUN) AND NOT queue_full AND NOT redirect_valid.
REQ-023 A fetch is accepted when fetch_valid AND icache_ready are both high.
REQ-024 On accept, the queue SHALL push {fetch_PC, next PC, target_take, BTB_hit}.
REQ-025 On accept, fetch_PC SHALL load target_PC if target_take is high, else fetch_PC+4.
REQ-026 The +4 SHALL wrap modulo 2^XLEN.
REQ-027 Every fetch_PC load SHALL force bits [1:0] to 0.
REQ-028 Without accept, fetch_PC SHALL hold.
REQ-029 deq_valid SHALL be count!=0; deq_valid AND deq_ready SHALL pop the head.
REQ-030 Pop SHALL present the next entry on the following cycle.
REQ-031 Push and pop in the same cycle SHALL leave count unchanged.
REQ-032 Read and write pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-033 queue_full SHALL use the registered count with no same-cycle pop bypass; a full queue blocks the push even when a pop occurs that cycle.
REQ-034 redirect_valid SHALL take priority over all other events: the queue empties, pushes and pops are suppressed, fetch_PC loads redirect_PC, and the state goes to FLUSH.
REQ-035 redirect_valid in any state SHALL have the effect in REQ-034, including IDLE and FLUSH; the last redirect wins.

Reset
REQ-036 While reset is low, fetch_PC SHALL be RESET_PC with bits [1:0] cleared, state IDLE, count 0, pointers 0, and fetch_valid, deq_valid and queue_full 0.
REQ-037 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-038 deq data outputs SHALL read as 0 while the queue is empty after reset.

Configuration
REQ-039 Macro FETCH_PC_STALL_COUNTER_EN, when defined, SHALL add output stall_count, 32 bits.
REQ-040 stall_count SHALL increment in each cycle with state==RUN and no accept, saturate at all-ones, and reset to 0.
REQ-041 When FETCH_PC_STALL_COUNTER_EN is undefined, the port and counter SHALL be absent and behaviour is otherwise identical.

Verification
REQ-042 Reset release with icache_ready=1, target_take=0, deq_ready=0 -> fetch_PC 0x0, 0x4, 0x8, 0xC accepted; queue_full=1 on the 5th cycle; fetch_valid=0.
REQ-043 Accept at fetch_PC=0x100 with target_take=1, target_PC=0x203 -> next fetch_PC=0x200; entry {0x100, 0x200, 1, BTB_hit}.
REQ-044 Full queue, deq_ready=1 for one cycle -> no push that cycle; push resumes next cycle; count returns to QUEUE_DEPTH.
REQ-045 redirect_valid=1, redirect_PC=0x8000, with a simultaneous accept and pop -> next cycle deq_valid=0, fetch_valid=0 (FLUSH); the following cycle fetch_PC=0x8000 and fetch_valid=1.
REQ-046 fetch_PC=0xFFFF_FFFF_FFFF_FFFC, not taken -> next fetch_PC=0x0.
REQ-047 Async reset pulse mid-stream with no clock edge -> outputs at reset values immediately; with FETCH_PC_STALL_COUNTER_EN, stall_count=0.
